// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: owner IDs and FSM states.
package mem_arbiter_pkg;

    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_e;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundled instruction, data and memory port signals of the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    ireq_i;
    logic [ADDR_WIDTH-1:0]   iaddr_i;
    logic                    igngt_o;
    logic                    irvalid_o;
    logic [DATA_WIDTH-1:0]   irdata_o;
    logic                    ierr_o;

    logic                    dreq_i;
    logic [ADDR_WIDTH-1:0]   daddr_i;
    logic                    dwe_i;
    logic [DATA_WIDTH/8-1:0] dbe_i;
    logic [DATA_WIDTH-1:0]   dwdata_i;
    logic                    dgnt_o;
    logic                    drvalid_o;
    logic [DATA_WIDTH-1:0]   drdata_o;
    logic                    derr_o;

    logic                    mreq_o;
    logic [ADDR_WIDTH-1:0]   maddr_o;
    logic                    mwe_o;
    logic [DATA_WIDTH/8-1:0] mbe_o;
    logic [DATA_WIDTH-1:0]   mwdata_o;
    logic                    mgnt_i;
    logic                    mrvalid_i;
    logic [DATA_WIDTH-1:0]   mrdata_i;
    logic                    merr_i;

    logic                    protocol_err_o;

    modport slave (
        input  ireq_i, iaddr_i,
        output igngt_o, irvalid_o, irdata_o, ierr_o,
        input  dreq_i, daddr_i, dwe_i, dbe_i, dwdata_i,
        output dgnt_o, drvalid_o, drdata_o, derr_o,
        output mreq_o, maddr_o, mwe_o, mbe_o, mwdata_o,
        input  mgnt_i, mrvalid_i, mrdata_i, merr_i,
        output protocol_err_o
    );

    modport master (
        output ireq_i, iaddr_i,
        input  igngt_o, irvalid_o, irdata_o, ierr_o,
        output dreq_i, daddr_i, dwe_i, dbe_i, dwdata_i,
        input  dgnt_o, drvalid_o, drdata_o, derr_o,
        input  mreq_o, maddr_o, mwe_o, mbe_o, mwdata_o,
        output mgnt_i, mrvalid_i, mrdata_i, merr_i,
        input  protocol_err_o
    );
endinterface

// File: rtl/mem_arbiter_owner_fifo.sv
// In-order FIFO of owner IDs for transfers accepted by memory but not yet answered.
module owner_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid memory port between instruction and data requesters.
//   state | meaning
//   IDLE  | pick a winner each cycle; present it if the owner FIFO has room
//   HOLD  | memory stalled the grant; owner locked until mgnt_i
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_OUTST  = 2
) (
    input logic          clk_i,
    input logic          rst_ni,
    mem_arbiter_if.slave bus
);
    localparam int BE_W  = DATA_WIDTH/8;
    localparam int CNT_W = $clog2(MAX_OUTST+1);

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d, last_q, last_d, winner;
    logic             perr_q, perr_d;
    logic             issue, accept, pop, fifo_full, fifo_empty;
    logic [0:0]       push_id, head_id;
    logic [CNT_W-1:0] fifo_count;

    always_comb begin
        winner = owner_q;
        issue  = 1'b0;
        if (state_q == HOLD) begin
            issue = 1'b1;
        end else if (!fifo_full && (bus.ireq_i || bus.dreq_i)) begin
            issue = 1'b1;
            if (bus.ireq_i && bus.dreq_i)
                winner = (last_q == OWNER_DATA) ? OWNER_INSTR : OWNER_DATA;
            else
                winner = bus.dreq_i ? OWNER_DATA : OWNER_INSTR;
        end
        issue = issue & rst_ni;
    end

    assign accept  = issue & bus.mgnt_i;
    assign pop     = bus.mrvalid_i & (fifo_count != '0) & rst_ni;
    assign push_id = winner;

    owner_fifo #(.DEPTH(MAX_OUTST), .WIDTH(1)) u_owner_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (accept),
        .data_i  (push_id),
        .pop_i   (pop),
        .data_o  (head_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        perr_d  = perr_q | (bus.mrvalid_i & fifo_empty);
        if (accept)
            last_d = winner;
        case (state_q)
            IDLE: if (issue && !bus.mgnt_i) begin
                state_d = HOLD;
                owner_d = winner;
            end
            HOLD: if (bus.mgnt_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            owner_q <= OWNER_INSTR;
            last_q  <= OWNER_INSTR;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            perr_q  <= perr_d;
        end
    end

    // Memory port mirrors the winner; everything is zero when nothing is presented.
    always_comb begin
        bus.mreq_o   = issue;
        bus.maddr_o  = '0;
        bus.mwe_o    = 1'b0;
        bus.mbe_o    = '0;
        bus.mwdata_o = '0;
        if (issue) begin
            if (winner == OWNER_DATA) begin
                bus.maddr_o  = bus.daddr_i;
                bus.mwe_o    = bus.dwe_i;
                bus.mbe_o    = bus.dbe_i;
                bus.mwdata_o = bus.dwdata_i;
            end else begin
                bus.maddr_o  = bus.iaddr_i;
                bus.mbe_o    = {BE_W{1'b1}};
            end
        end
    end

    assign bus.igngt_o        = accept & (winner == OWNER_INSTR);
    assign bus.dgnt_o         = accept & (winner == OWNER_DATA);
    assign bus.irvalid_o      = pop & (head_id == OWNER_INSTR);
    assign bus.drvalid_o      = pop & (head_id == OWNER_DATA);
    assign bus.irdata_o       = bus.mrdata_i;
    assign bus.drdata_o       = bus.mrdata_i;
    assign bus.ierr_o         = bus.irvalid_o & bus.merr_i;
    assign bus.derr_o         = bus.drvalid_o & bus.merr_i;
    assign bus.protocol_err_o = perr_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single read, round robin, stall lock, full FIFO, protocol error, mid-transfer reset.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTST(2)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    task automatic quiet();
        bus.ireq_i = 0; bus.iaddr_i = '0;
        bus.dreq_i = 0; bus.daddr_i = '0; bus.dwe_i = 0; bus.dbe_i = '0; bus.dwdata_i = '0;
        bus.mgnt_i = 0; bus.mrvalid_i = 0; bus.mrdata_i = '0; bus.merr_i = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 0;
        quiet();
        bus.ireq_i = 1; bus.dreq_i = 1; bus.mgnt_i = 1; bus.mrvalid_i = 1;
        #1;
        total++; if (bus.mreq_o !== 1'b0) begin bad++; $display("FAIL reset_mreq got=%b exp=0", bus.mreq_o); end
        total++; if ({bus.igngt_o, bus.dgnt_o} !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b exp=00", {bus.igngt_o, bus.dgnt_o}); end
        total++; if ({bus.irvalid_o, bus.drvalid_o} !== 2'b00) begin bad++; $display("FAIL reset_rvalid got=%b exp=00", {bus.irvalid_o, bus.drvalid_o}); end
        total++; if (bus.maddr_o !== 32'h0 || bus.mbe_o !== 4'h0) begin bad++; $display("FAIL reset_mport got=%h/%h exp=0/0", bus.maddr_o, bus.mbe_o); end
        total++; if (bus.protocol_err_o !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b exp=0", bus.protocol_err_o); end
        @(negedge clk);
        quiet();
        rst_n = 1;
    endtask

    task automatic test_single_instr();
        @(negedge clk);
        quiet(); bus.ireq_i = 1; bus.iaddr_i = 32'h10; bus.mgnt_i = 1;
        #1;
        total++; if (bus.mreq_o !== 1'b1 || bus.maddr_o !== 32'h10) begin bad++; $display("FAIL single_req got=%b/%h exp=1/00000010", bus.mreq_o, bus.maddr_o); end
        total++; if (bus.mwe_o !== 1'b0 || bus.mbe_o !== 4'hf || bus.mwdata_o !== 32'h0) begin bad++; $display("FAIL single_ifields got=%b/%h/%h exp=0/f/0", bus.mwe_o, bus.mbe_o, bus.mwdata_o); end
        total++; if ({bus.igngt_o, bus.dgnt_o} !== 2'b10) begin bad++; $display("FAIL single_gnt got=%b exp=10", {bus.igngt_o, bus.dgnt_o}); end
        @(negedge clk);
        quiet(); bus.mrvalid_i = 1; bus.mrdata_i = 32'hDEADBEEF;
        #1;
        total++; if (bus.igngt_o !== 1'b0) begin bad++; $display("FAIL single_gnt_drop got=%b exp=0", bus.igngt_o); end
        total++; if ({bus.irvalid_o, bus.drvalid_o} !== 2'b10) begin bad++; $display("FAIL single_rvalid got=%b exp=10", {bus.irvalid_o, bus.drvalid_o}); end
        total++; if (bus.irdata_o !== 32'hDEADBEEF || bus.ierr_o !== 1'b0) begin bad++; $display("FAIL single_rdata got=%h/%b exp=deadbeef/0", bus.irdata_o, bus.ierr_o); end
        @(negedge clk);
        quiet();
        #1;
        total++; if (bus.irvalid_o !== 1'b0) begin bad++; $display("FAIL single_rvalid_pulse got=%b exp=0", bus.irvalid_o); end
    endtask

    task automatic test_round_robin();
        // grants D,I,D,I; each response one cycle after its grant
        logic [1:0] exp_gnt [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
        logic [1:0] exp_rv  [5] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
        logic [31:0] exp_addr [5] = '{32'h80, 32'h40, 32'h80, 32'h40, 32'h0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            quiet();
            bus.iaddr_i = 32'h40; bus.daddr_i = 32'h80;
            bus.ireq_i = (i < 4); bus.dreq_i = (i < 4); bus.mgnt_i = 1;
            bus.mrvalid_i = (i > 0); bus.mrdata_i = 32'h100 + i;
            #1;
            total++; if ({bus.igngt_o, bus.dgnt_o} !== exp_gnt[i]) begin bad++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", i, {bus.igngt_o, bus.dgnt_o}, exp_gnt[i]); end
            total++; if ({bus.irvalid_o, bus.drvalid_o} !== exp_rv[i]) begin bad++; $display("FAIL rr_rvalid[%0d] got=%b exp=%b", i, {bus.irvalid_o, bus.drvalid_o}, exp_rv[i]); end
            total++; if (bus.maddr_o !== exp_addr[i]) begin bad++; $display("FAIL rr_addr[%0d] got=%h exp=%h", i, bus.maddr_o, exp_addr[i]); end
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            quiet();
            bus.dreq_i = 1; bus.daddr_i = 32'h20; bus.dwe_i = 1; bus.dbe_i = 4'b0011; bus.dwdata_i = 32'hCAFE;
            bus.ireq_i = (i > 0); bus.iaddr_i = 32'h30;
            bus.mgnt_i = (i == 3);
            #1;
            total++; if (bus.mreq_o !== 1'b1 || bus.maddr_o !== 32'h20 || bus.mwe_o !== 1'b1 || bus.mbe_o !== 4'b0011) begin
                bad++; $display("FAIL hold_mport[%0d] got=%b/%h/%b/%h exp=1/00000020/1/3", i, bus.mreq_o, bus.maddr_o, bus.mwe_o, bus.mbe_o); end
            total++; if ({bus.igngt_o, bus.dgnt_o} !== ((i == 3) ? 2'b01 : 2'b00)) begin bad++; $display("FAIL hold_gnt[%0d] got=%b exp=%b", i, {bus.igngt_o, bus.dgnt_o}, (i == 3) ? 2'b01 : 2'b00); end
        end
        @(negedge clk);
        quiet(); bus.ireq_i = 1; bus.iaddr_i = 32'h30; bus.mgnt_i = 1;
        #1;
        total++; if (bus.igngt_o !== 1'b1 || bus.maddr_o !== 32'h30 || bus.mwe_o !== 1'b0) begin bad++; $display("FAIL hold_instr_after got=%b/%h/%b exp=1/00000030/0", bus.igngt_o, bus.maddr_o, bus.mwe_o); end
        @(negedge clk);
        quiet(); bus.mrvalid_i = 1; bus.merr_i = 1; bus.mrdata_i = 32'h1;
        #1;
        total++; if ({bus.drvalid_o, bus.derr_o, bus.irvalid_o, bus.ierr_o} !== 4'b1100) begin bad++; $display("FAIL hold_derr got=%b exp=1100", {bus.drvalid_o, bus.derr_o, bus.irvalid_o, bus.ierr_o}); end
        @(negedge clk);
        quiet(); bus.mrvalid_i = 1; bus.mrdata_i = 32'h2;
        #1;
        total++; if ({bus.irvalid_o, bus.drvalid_o} !== 2'b10) begin bad++; $display("FAIL hold_irsp got=%b exp=10", {bus.irvalid_o, bus.drvalid_o}); end
    endtask

    task automatic test_full();
        logic [1:0] exp_gnt [5] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b01};
        logic       exp_req [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            quiet();
            bus.ireq_i = 1; bus.dreq_i = 1; bus.mgnt_i = 1;
            bus.mrvalid_i = (i == 3);
            #1;
            total++; if (bus.mreq_o !== exp_req[i]) begin bad++; $display("FAIL full_mreq[%0d] got=%b exp=%b", i, bus.mreq_o, exp_req[i]); end
            total++; if ({bus.igngt_o, bus.dgnt_o} !== exp_gnt[i]) begin bad++; $display("FAIL full_gnt[%0d] got=%b exp=%b", i, {bus.igngt_o, bus.dgnt_o}, exp_gnt[i]); end
            if (i == 3) begin
                total++; if ({bus.irvalid_o, bus.drvalid_o} !== 2'b01) begin bad++; $display("FAIL full_rsp got=%b exp=01", {bus.irvalid_o, bus.drvalid_o}); end
            end
        end
        @(negedge clk);
        quiet(); bus.mrvalid_i = 1;
        #1;
        total++; if ({bus.irvalid_o, bus.drvalid_o} !== 2'b10) begin bad++; $display("FAIL full_drain0 got=%b exp=10", {bus.irvalid_o, bus.drvalid_o}); end
        @(negedge clk);
        quiet(); bus.mrvalid_i = 1;
        #1;
        total++; if ({bus.irvalid_o, bus.drvalid_o} !== 2'b01) begin bad++; $display("FAIL full_drain1 got=%b exp=01", {bus.irvalid_o, bus.drvalid_o}); end
    endtask

    task automatic test_protocol_err();
        @(negedge clk);
        quiet(); bus.mrvalid_i = 1;
        #1;
        total++; if ({bus.irvalid_o, bus.drvalid_o} !== 2'b00) begin bad++; $display("FAIL perr_rvalid got=%b exp=00", {bus.irvalid_o, bus.drvalid_o}); end
        total++; if (bus.protocol_err_o !== 1'b0) begin bad++; $display("FAIL perr_early got=%b exp=0", bus.protocol_err_o); end
        repeat (3) @(negedge clk);
        quiet();
        #1;
        total++; if (bus.protocol_err_o !== 1'b1) begin bad++; $display("FAIL perr_sticky got=%b exp=1", bus.protocol_err_o); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        quiet(); bus.dreq_i = 1; bus.daddr_i = 32'h44; bus.mgnt_i = 1;
        #1;
        total++; if (bus.dgnt_o !== 1'b1) begin bad++; $display("FAIL rmid_pre_gnt got=%b exp=1", bus.dgnt_o); end
        @(negedge clk);
        rst_n = 0;
        bus.mrvalid_i = 1;
        #1;
        total++; if ({bus.mreq_o, bus.dgnt_o, bus.igngt_o, bus.irvalid_o, bus.drvalid_o} !== 5'b0) begin
            bad++; $display("FAIL rmid_outs got=%b exp=00000", {bus.mreq_o, bus.dgnt_o, bus.igngt_o, bus.irvalid_o, bus.drvalid_o}); end
        total++; if (bus.protocol_err_o !== 1'b0) begin bad++; $display("FAIL rmid_perr_clr got=%b exp=0", bus.protocol_err_o); end
        @(negedge clk);
        rst_n = 1;
        quiet(); bus.mrvalid_i = 1;
        #1;
        total++; if ({bus.irvalid_o, bus.drvalid_o} !== 2'b00) begin bad++; $display("FAIL rmid_stale_rsp got=%b exp=00", {bus.irvalid_o, bus.drvalid_o}); end
        @(negedge clk);
        quiet(); bus.ireq_i = 1; bus.iaddr_i = 32'h10; bus.mgnt_i = 1;
        #1;
        total++; if (bus.protocol_err_o !== 1'b1) begin bad++; $display("FAIL rmid_perr_set got=%b exp=1", bus.protocol_err_o); end
        total++; if (bus.igngt_o !== 1'b1 || bus.maddr_o !== 32'h10) begin bad++; $display("FAIL rmid_igrant got=%b/%h exp=1/00000010", bus.igngt_o, bus.maddr_o); end
        @(negedge clk);
        quiet(); bus.mrvalid_i = 1; bus.mrdata_i = 32'h55;
        #1;
        total++; if ({bus.irvalid_o, bus.drvalid_o} !== 2'b10 || bus.irdata_o !== 32'h55) begin
            bad++; $display("FAIL rmid_irsp got=%b/%h exp=10/00000055", {bus.irvalid_o, bus.drvalid_o}, bus.irdata_o); end
        @(negedge clk);
        quiet();
    endtask

    initial begin
        quiet();
        test_reset();
        test_single_instr();
        test_round_robin();
        test_hold();
        test_full();
        test_protocol_err();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
